// File: rtl/lfsr_rq_gen.sv
// Per-channel LFSR-driven request generator with req/gnt handshake.
// Starvation monitor compiled in when LFSR_RQ_STARVE_EN is defined.
module lfsr_rq_gen #(
  parameter int unsigned          N_CH     = 4,
  parameter int unsigned          WIDTH    = 8,
  parameter logic [WIDTH-1:0]     TAPS     = 8'hB8,
  parameter logic [WIDTH-1:0]     SEED     = 8'h01,
  parameter int unsigned          MAX_WAIT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             reload,
  input  logic [WIDTH-1:0] density,
  input  logic [N_CH-1:0]  gnt,
  input  logic             clear_starve,
  output logic [N_CH-1:0]  rq,
  output logic [N_CH-1:0]  starve
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_GAP
  } st_e;

  function automatic logic [WIDTH-1:0] seed_of(int unsigned ch);
    logic [2*WIDTH-1:0] t;
    t = {SEED, SEED} << (ch % WIDTH);
    return t[2*WIDTH-1:WIDTH];
  endfunction

  logic [WIDTH-1:0] lfsr_q [N_CH];
  logic [WIDTH-1:0] lfsr_d [N_CH];
  st_e              st_q   [N_CH];
  st_e              st_d   [N_CH];
  logic [N_CH-1:0]  rq_q, rq_d;
  logic [N_CH-1:0]  trig;

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      lfsr_d[i] = lfsr_q[i];
      st_d[i]   = st_q[i];
      trig[i]   = enable && (lfsr_q[i] <= density) && (density != '0);
      // an all-zero state would never leave, so it is reseeded
      if (reload || lfsr_q[i] == '0) begin
        lfsr_d[i] = seed_of(i);
      end else if (enable) begin
        lfsr_d[i] = {lfsr_q[i][WIDTH-2:0], ^(lfsr_q[i] & TAPS)};
      end
      case (st_q[i])
        S_IDLE:  if (trig[i]) st_d[i] = S_REQ;
        S_REQ:   if (gnt[i])  st_d[i] = S_GAP;
        S_GAP:   st_d[i] = S_IDLE;
        default: st_d[i] = S_IDLE;
      endcase
      rq_d[i] = (st_d[i] == S_REQ);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++) begin
        lfsr_q[i] <= seed_of(i);
        st_q[i]   <= S_IDLE;
      end
      rq_q <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        lfsr_q[i] <= lfsr_d[i];
        st_q[i]   <= st_d[i];
      end
      rq_q <= rq_d;
    end
  end

  assign rq = rq_q;

`ifdef LFSR_RQ_STARVE_EN
  localparam int unsigned CW = $clog2(MAX_WAIT + 1);

  logic [CW-1:0]   cnt_q [N_CH];
  logic [CW-1:0]   cnt_d [N_CH];
  logic [N_CH-1:0] stv_q, stv_d;

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (st_q[i] != S_REQ && st_d[i] == S_REQ) begin
        cnt_d[i] = '0;
      end else if (st_q[i] == S_REQ && cnt_q[i] != CW'(MAX_WAIT)) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
      // set only on the edge the bound is reached; set beats clear
      stv_d[i] = (stv_q[i] && !clear_starve) ||
                 (st_q[i] == S_REQ && !gnt[i] &&
                  cnt_q[i] == CW'(MAX_WAIT - 1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++) cnt_q[i] <= '0;
      stv_q <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) cnt_q[i] <= cnt_d[i];
      stv_q <= stv_d;
    end
  end

  assign starve = stv_q;
`else
  logic unused_clear;
  assign unused_clear = clear_starve;
  assign starve       = '0;
`endif

endmodule
